// File: rtl/serial_word_pkg.sv
// Shared definitions for the serial word loader: default word width,
// FSM state encoding and the bit counter width helper.
package serial_word_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_STALL   = 1'b1
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/word_slot.sv
// One-word output holding register with a valid/ready handshake.
// Ports: clk, rst_n; load/load_data fill the slot; word_ready consumes;
// word_out/word_valid are the registered slot contents and flag.
module word_slot
   import serial_word_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             word_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid
);

   // A load wins over a consume on the same edge: the consumer takes
   // the old word and the slot is refilled with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_out   <= '0;
         word_valid <= 1'b0;
      end else if (load) begin
         word_out   <= load_data;
         word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_loader.sv
// Assembles an LSB-first serial bit stream into WIDTH-bit words.
// Ports: clk, rst_n; serial in sin_valid/sin_bit/sin_first, sin_ready;
// word out word_out/word_valid/word_ready; frame_err resync pulse.
module serial_word_loader
   import serial_word_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin_valid,
   input  logic             sin_bit,
   input  logic             sin_first,
   output logic             sin_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             frame_err
);

   localparam int unsigned   CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    bit_cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    wr_pos;
   logic             accept;
   logic             consume;
   logic             resync;
   logic             last_bit;
   logic             load;
   logic             err_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_COLLECT;
         shreg     <= '0;
         bit_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= cnt_nxt;
         frame_err <= err_nxt;
      end
   end

   always_comb begin
      sin_ready = (state == ST_COLLECT);
      accept    = sin_valid & sin_ready;
      consume   = word_valid & word_ready;
      resync    = accept & sin_first;
      // A resync marker always starts a new word, even at the last
      // position, so it never completes the word in progress.
      last_bit  = accept & ~sin_first & (bit_cnt == LAST);
      wr_pos    = sin_first ? '0 : bit_cnt;

      shreg_nxt = shreg;
      if (accept) begin
         shreg_nxt[wr_pos] = sin_bit;
      end

      state_nxt = state;
      cnt_nxt   = bit_cnt;
      load      = 1'b0;
      err_nxt   = resync & (bit_cnt != '0);

      unique case (state)
         ST_COLLECT: begin
            if (resync) begin
               cnt_nxt = CW'(1);
            end else if (last_bit) begin
               if (!word_valid || word_ready) begin
                  load    = 1'b1;
                  cnt_nxt = '0;
               end else begin
                  state_nxt = ST_STALL;
               end
            end else if (accept) begin
               cnt_nxt = bit_cnt + 1'b1;
            end
         end
         ST_STALL: begin
            if (consume) begin
               load      = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_COLLECT;
            end
         end
         default: begin
            state_nxt = ST_COLLECT;
         end
      endcase
   end

   // shreg_nxt equals shreg in STALL, so one data path serves both
   // the direct completion load and the deferred load after a stall.
   word_slot #(
      .WIDTH(WIDTH)
   ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (shreg_nxt),
      .word_ready(word_ready),
      .word_out  (word_out),
      .word_valid(word_valid)
   );

endmodule
